// File: rtl/pixel_dispatch_scheduler.sv
// rtl/pixel_dispatch_scheduler.sv - Raster-scan Mandelbrot job sequencer with round-robin engine dispatch.
// Optional macro PIXEL_SCHED_PERF_EN adds the stall_cycles counter output.
module pixel_dispatch_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FRAC          = 8,
  parameter int NUM_ENGINES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            re_min,
  input  logic [15:0]            im_max,
  input  logic [15:0]            step,
  input  logic [NUM_ENGINES-1:0] eng_ready,
  output logic [NUM_ENGINES-1:0] eng_valid,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic [15:0]            c_re,
  output logic [15:0]            c_im,
  output logic                   busy,
  output logic                   frame_done
`ifdef PIXEL_SCHED_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  if (NUM_ENGINES < 1 || NUM_ENGINES > 8) begin : g_bad_engines
    $error("NUM_ENGINES must be in 1..8");
  end
  if (FRAC < 0 || FRAC > 15) begin : g_bad_frac
    $error("FRAC must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DISPATCH, S_DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    rr_ptr, gnt_idx, next_ptr, scan_base, pick_idx;
  logic [NUM_ENGINES-1:0] pick_onehot;
  logic             pick_found;
  logic             transfer, end_of_row, last_pixel;
  logic [15:0]      lat_re, lat_step;
  int               off, best_off;

  assign transfer   = |(eng_valid & eng_ready);
  assign end_of_row = (pix_x == 10'(SCREEN_WIDTH - 1));
  assign last_pixel = end_of_row && (pix_y == 9'(SCREEN_HEIGHT - 1));
  assign next_ptr   = (int'(gnt_idx) == NUM_ENGINES - 1) ? '0 : gnt_idx + 1'b1;

  // On a transfer the next scan starts just past the engine that took the job.
  assign scan_base  = transfer ? next_ptr : rr_ptr;

  always_comb begin
    best_off = NUM_ENGINES;
    pick_idx = '0;
    off      = 0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      off = e - int'(scan_base);
      if (off < 0) off = off + NUM_ENGINES;
      if (eng_ready[e] && off < best_off) begin
        best_off = off;
        pick_idx = PW'(e);
      end
    end
    pick_found  = (best_off < NUM_ENGINES);
    pick_onehot = pick_found ? (NUM_ENGINES'(1) << pick_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_LOAD;
      S_LOAD:     state_next = S_DISPATCH;
      S_DISPATCH: if (transfer && last_pixel) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == S_LOAD) || (state == S_DISPATCH);
    frame_done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eng_valid <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      c_re      <= '0;
      c_im      <= '0;
      lat_re    <= '0;
      lat_step  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          lat_re    <= re_min;
          lat_step  <= step;
          pix_x     <= '0;
          pix_y     <= '0;
          c_re      <= re_min;
          c_im      <= im_max;
          eng_valid <= pick_onehot;
          gnt_idx   <= pick_idx;
        end
        S_DISPATCH: begin
          if (transfer) begin
            rr_ptr <= next_ptr;
            if (last_pixel) begin
              eng_valid <= '0;
            end else begin
              if (end_of_row) begin
                pix_x <= '0;
                pix_y <= pix_y + 9'd1;
                c_re  <= lat_re;
                c_im  <= c_im - lat_step;
              end else begin
                pix_x <= pix_x + 10'd1;
                c_re  <= c_re + lat_step;
              end
              eng_valid <= pick_onehot;
              gnt_idx   <= pick_idx;
            end
          end else if (eng_valid == '0) begin
            // Nothing granted yet: keep scanning; a held grant is never re-arbitrated.
            eng_valid <= pick_onehot;
            gnt_idx   <= pick_idx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIXEL_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                                stall_cycles <= '0;
    else if (state == S_LOAD)               stall_cycles <= '0;
    else if (state == S_DISPATCH && !transfer) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
// tb/tb_pixel_dispatch_scheduler.sv - Bench for pixel_dispatch_scheduler, one N=1 and one N=3 instance.
module tb_pixel_dispatch_scheduler;
  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] re_min, im_max, step;
  logic [0:0]  rdy1, ev1;
  logic [2:0]  rdy3, ev3;
  logic [9:0]  px1, px3;
  logic [8:0]  py1, py3;
  logic [15:0] re1, re3, im1, im3;
  logic        busy1, busy3, done1, done3;
  logic [31:0] st1, st3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  pixel_dispatch_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAC(8), .NUM_ENGINES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .re_min(re_min), .im_max(im_max), .step(step),
    .eng_ready(rdy1), .eng_valid(ev1), .pix_x(px1), .pix_y(py1), .c_re(re1), .c_im(im1),
    .busy(busy1), .frame_done(done1)
`ifdef PIXEL_SCHED_PERF_EN
    , .stall_cycles(st1)
`endif
  );

  pixel_dispatch_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAC(8), .NUM_ENGINES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .re_min(re_min), .im_max(im_max), .step(step),
    .eng_ready(rdy3), .eng_valid(ev3), .pix_x(px3), .pix_y(py3), .c_re(re3), .c_im(im3),
    .busy(busy3), .frame_done(done3)
`ifdef PIXEL_SCHED_PERF_EN
    , .stall_cycles(st3)
`endif
  );

`ifndef PIXEL_SCHED_PERF_EN
  assign st1 = '0;
  assign st3 = '0;
`endif

  logic [7:0]  d_ev[2], d_rdy[2];
  logic [9:0]  d_px[2];
  logic [8:0]  d_py[2];
  logic [15:0] d_re[2], d_im[2];
  logic        d_busy[2], d_done[2];
  logic [31:0] d_st[2];

  always_comb begin
    d_ev[0] = {7'b0, ev1};   d_ev[1] = {5'b0, ev3};
    d_rdy[0] = {7'b0, rdy1}; d_rdy[1] = {5'b0, rdy3};
    d_px[0] = px1;  d_px[1] = px3;
    d_py[0] = py1;  d_py[1] = py3;
    d_re[0] = re1;  d_re[1] = re3;
    d_im[0] = im1;  d_im[1] = im3;
    d_busy[0] = busy1; d_busy[1] = busy3;
    d_done[0] = done1; d_done[1] = done3;
    d_st[0] = st1;  d_st[1] = st3;
  end

  task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, m, act, exp, $time);
    end
  endtask

  function automatic int nen(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int arb(input int n, input int p, input logic [7:0] r);
    for (int i = 0; i < n; i++) begin
      int e;
      e = (p + i) % n;
      if (r[e[2:0]]) return e;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: frame phase, linear pixel index, held engine, RR start; coordinates come from x*step arithmetic.
  int          mst[2], mk[2], mg[2], mptr[2], mstall[2];
  logic [15:0] mre[2], mim[2], mstep[2];

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int st, k, g, p, sc;
      logic [15:0] r, im, s;
      st = mst[m]; k = mk[m]; g = mg[m]; p = mptr[m]; sc = mstall[m];
      r = mre[m]; im = mim[m]; s = mstep[m];
      if (rst) begin
        st = 0; k = 0; g = -1; p = 0; sc = 0; r = '0; im = '0; s = '0;
      end else begin
        case (st)
          0: if (start) st = 1;
          1: begin
            r = re_min; im = im_max; s = step; k = 0; sc = 0;
            g = arb(nen(m), p, d_rdy[m]);
            st = 2;
          end
          2: begin
            if (g >= 0 && d_rdy[m][g[2:0]]) begin
              p = (g + 1) % nen(m);
              if (k == W * H - 1) begin
                g = -1; st = 3;
              end else begin
                k = k + 1;
                g = arb(nen(m), p, d_rdy[m]);
              end
            end else begin
              sc = sc + 1;
              if (g < 0) g = arb(nen(m), p, d_rdy[m]);
            end
          end
          default: st = 0;
        endcase
      end
      mst[m] <= st; mk[m] <= k; mg[m] <= g; mptr[m] <= p; mstall[m] <= sc;
      mre[m] <= r; mim[m] <= im; mstep[m] <= s;
    end
  end

  // Transfer log per frame, observed from the DUT pins.
  int          log_n[2], log_e[2][32], log_cyc[2][32], start_cyc[2], done_cyc[2];
  logic [9:0]  log_x[2][32];
  logic [8:0]  log_y[2][32];
  logic [15:0] log_re[2][32], log_im[2][32];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int m = 0; m < 2; m++) begin
      if (!rst && start && mst[m] == 0) begin
        log_n[m] <= 0;
        start_cyc[m] <= cyc;
      end else if (|(d_ev[m] & d_rdy[m]) && log_n[m] < 32) begin
        log_x[m][log_n[m]]   <= d_px[m];
        log_y[m][log_n[m]]   <= d_py[m];
        log_re[m][log_n[m]]  <= d_re[m];
        log_im[m][log_n[m]]  <= d_im[m];
        log_e[m][log_n[m]]   <= oh_idx(d_ev[m]);
        log_cyc[m][log_n[m]] <= cyc;
        log_n[m] <= log_n[m] + 1;
      end
      if (d_done[m]) done_cyc[m] <= cyc;
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [7:0]  eev;
      logic [15:0] ere, eim;
      int x, y;
      eev = (mg[m] >= 0) ? (8'd1 << mg[m]) : 8'd0;
      chk("eng_valid", m, 64'(d_ev[m]), 64'(eev));
      chk("busy", m, 64'(d_busy[m]), 64'(mst[m] == 1 || mst[m] == 2));
      chk("frame_done", m, 64'(d_done[m]), 64'(mst[m] == 3));
      if (eev != 8'd0) begin
        x = mk[m] % W;
        y = mk[m] / W;
        ere = mre[m] + 16'(x) * mstep[m];
        eim = mim[m] - 16'(y) * mstep[m];
        chk("pix_x", m, 64'(d_px[m]), 64'(x));
        chk("pix_y", m, 64'(d_py[m]), 64'(y));
        chk("c_re", m, 64'(d_re[m]), 64'(ere));
        chk("c_im", m, 64'(d_im[m]), 64'(eim));
      end
`ifdef PIXEL_SCHED_PERF_EN
      chk("stall_cycles", m, 64'(d_st[m]), 64'(mstall[m]));
`endif
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mst[0] != 0 || mst[1] != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 0, 64'(n < 300), 64'd1);
  endtask

  task automatic chk_order(input string name);
    int bad;
    for (int m = 0; m < 2; m++) begin
      bad = 0;
      for (int k = 0; k < W * H; k++)
        if (int'(log_x[m][k]) != k % W || int'(log_y[m][k]) != k / W) bad++;
      chk({name, "_count"}, m, 64'(log_n[m]), 64'(W * H));
      chk({name, "_order"}, m, 64'(bad), 64'd0);
    end
  endtask

  initial begin
    int bad;
    int exp_e[8];
    rst = 1'b1; start = 1'b0; rdy1 = 1'b0; rdy3 = 3'b000;
    re_min = 16'hFE00; im_max = 16'h0200; step = 16'h0040;
    repeat (3) @(negedge clk);
    chk("rst_valid", 0, 64'(ev1), 64'd0);
    chk("rst_valid", 1, 64'(ev3), 64'd0);
    chk("rst_outs", 0, {px1, py1, re1, im1, busy1, done1}, 64'd0);
    rst = 1'b0;

    // Frame A: N=1 streams; N=3 round robin, then engine 1 withdrawn.
    rdy1 = 1'b1; rdy3 = 3'b111;
    pulse_start();
    repeat (4) @(negedge clk);
    rdy3 = 3'b101;
    wait_idle();
    rdy3 = 3'b111;
    chk_order("a");
    chk("t1_first", 0, {log_x[0][0], log_y[0][0], log_re[0][0], log_im[0][0]},
        {10'd0, 9'd0, 16'hFE00, 16'h0200});
    chk("t1_x3_re", 0, 64'(log_re[0][3]), 64'hFEC0);
    chk("t1_row1", 0, {log_x[0][4], log_y[0][4], log_re[0][4], log_im[0][4]},
        {10'd0, 9'd1, 16'hFE00, 16'h01C0});
    chk("t1_last", 0, {log_x[0][11], log_y[0][11], log_re[0][11], log_im[0][11]},
        {10'd3, 9'd2, 16'hFEC0, 16'h0180});
    chk("t1_consecutive", 0, 64'(log_cyc[0][11] - log_cyc[0][0]), 64'd11);
    chk("t1_done_after_last", 0, 64'(done_cyc[0] - log_cyc[0][11]), 64'd1);
    chk("t1_latency", 0, 64'(log_cyc[0][0] - start_cyc[0]), 64'd2);
    exp_e = '{0, 1, 2, 0, 2, 0, 2, 0};
    bad = 0;
    for (int k = 0; k < 8; k++) if (log_e[1][k] != exp_e[k]) bad++;
    chk("t2_grant_seq", 1, 64'(bad), 64'd0);

    // Frame B: 5-cycle total stall, plus ignored restart with a new re_min.
    pulse_start();
    repeat (3) @(negedge clk);
    rdy1 = 1'b0; rdy3 = 3'b000;
    repeat (2) @(negedge clk);
    chk("t3_grant_held", 0, 64'(ev1), 64'd1);
    re_min = 16'h0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rdy1 = 1'b1; rdy3 = 3'b111;
    wait_idle();
    chk_order("b");
    for (int m = 0; m < 2; m++) begin
      bad = 0;
      for (int k = 0; k < W * H; k++)
        if (log_re[m][k] != 16'hFE00 + 16'(k % W) * 16'h0040) bad++;
      chk("t4_re_latched", m, 64'(bad), 64'd0);
    end
`ifdef PIXEL_SCHED_PERF_EN
    chk("t3_stall", 0, 64'(st1), 64'd5);
    chk("t3_stall", 1, 64'(st3), 64'd5);
`endif

    // Frame C: new re_min takes effect.
    pulse_start();
    wait_idle();
    chk("t4_new_re", 0, 64'(log_re[0][0]), 64'h0000);
    chk("t4_new_re", 1, 64'(log_re[1][3]), 64'h00C0);

    // Frame D: reset while pixel (2,1) is presented.
    pulse_start();
    repeat (7) @(negedge clk);
    chk("t5_at_pixel", 0, {px1, py1}, {10'd2, 9'd1});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_valid", 0, 64'(ev1), 64'd0);
    chk("t5_rst_valid", 1, 64'(ev3), 64'd0);
    chk("t5_rst_outs", 0, {px1, py1, re1, im1, busy1, done1}, 64'd0);
    chk("t5_rst_outs", 1, {px3, py3, re3, im3, busy3, done3}, 64'd0);

    // Frame E: rescan from (0,0) with wrapping arithmetic.
    re_min = 16'h7FFF; step = 16'h7FFF; im_max = 16'h0200;
    pulse_start();
    wait_idle();
    chk_order("e");
    chk("t6_first", 0, {log_x[0][0], log_y[0][0], log_re[0][0]}, {10'd0, 9'd0, 16'h7FFF});
    chk("t6_wrap_re", 0, 64'(log_re[0][1]), 64'hFFFE);
    chk("t6_wrap_im", 0, 64'(log_im[0][4]), 64'h8201);
    chk("t6_ptr_reset", 1, 64'(log_e[1][0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
